d_mem_rsp: RTL and testbench
============================

# d_mem_rsp

Data-memory responder for the simple core's load/store port. Accepts one load or store request per cycle over a valid/ready handshake and serves it from an internal byte-addressable array that occupies [D_MEM_OFFSET, D_MEM_OFFSET+D_MEM_SIZE). Returns one registered response per request, with load data already sign- or zero-extended according to funct3. Sits on the memory side of the core's data interface, opposite the core's load/store stage.

## Interface
- D_MEM_OFFSET, 'h1000: byte base address of the data memory.
- D_MEM_SIZE, 'h1000: size in bytes; a power of two, at least 4. The array holds D_MEM_SIZE/4 words of 32 bits.
- Clock  in  1  single clock; all state updates on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  request can be accepted this cycle.
- ReqWrEn  in  1  1 = store, 0 = load.
- ReqAddr  in  32  byte address.
- ReqFunct3  in  3  RV32I load/store funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- ReqWrData  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- RspValid  out  1  response present.
- RspReady  in  1  consumer accepts the response.
- RspRdData  out  32  extended load data; 0 for stores and errors.
- RspErr  out  1  access error (see Configuration).

## Operation
- ReqReady = !Rst && (!RspValid || RspReady). This is combinational. A request is accepted when ReqValid && ReqReady.
- Every accepted request produces exactly one response. Stores also respond, with RspRdData=0.
- Offset: off = ReqAddr - D_MEM_OFFSET, computed unsigned at 32 bits. Word index = off[log2(D_MEM_SIZE)-1:2]. Lane = ReqAddr[1:0].
- Store byte enables:
  - SB: the single lane ReqAddr[1:0], written with ReqWrData[7:0].
  - SH: lanes {ReqAddr[1],0} and {ReqAddr[1],1}, written with ReqWrData[15:0].
  - SW: all four lanes.
  - The write commits on the accepting edge.
- Loads read the full word at the index, extract the byte or halfword at the lane, then extend:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: the word unchanged.
- Error cases (with DMEM_RANGE_CHK_EN):
  - off >= D_MEM_SIZE;
  - halfword access with ReqAddr[0]=1;
  - word access with ReqAddr[1:0]≠0;
  - invalid funct3 (loads 011/110/111; stores other than 000–010).
- On error: no array write, RspErr=1, RspRdData=0.
- Array contents are not reset and are X until written.
- Rst clears RspValid, RspRdData and RspErr to 0, and forces ReqReady=0. A response pending at reset is discarded. No request is accepted, and no write occurs, in a cycle with Rst=1.

## Timing
- Latency: response registered; RspValid rises on the edge after acceptance (1 cycle).
- Response hold: RspValid, RspRdData and RspErr stay stable while RspValid && !RspReady.
- Throughput: one request per cycle while RspReady=1. In a cycle where a response is accepted, a new request may be accepted, and its response replaces the old one with no bubble.
- Back-pressure: while RspValid && !RspReady, ReqReady=0 and requests wait.
- Read-after-write: a store accepted in cycle n is visible to a load accepted in cycle n+1.
- Reset values: RspValid=0, RspRdData=0, RspErr=0. ReqReady is 0 during Rst and 1 in the first cycle after Rst deasserts.

## Configuration
- Macro: DMEM_RANGE_CHK_EN.
- Defined: range, alignment and funct3 checks are performed as in Operation, and RspErr reports them.
- Undefined:
  - RspErr is tied to 0.
  - The index wraps modulo D_MEM_SIZE; upper address bits are ignored.
  - Halfword accesses ignore ReqAddr[0]; word accesses ignore ReqAddr[1:0].
  - Invalid load funct3 acts as LW; invalid store funct3 acts as SW.

## Test plan
- Reset: hold Rst for 3 cycles with ReqValid=1 -> RspValid=0, ReqReady=0, no write. The cycle after release -> ReqReady=1.
- Word round trip: SW 0xDEADBEEF @0x1004, then LW @0x1004 -> the store response has RspRdData=0, RspErr=0. The load response, one cycle after its acceptance, has RspRdData=0xDEADBEEF.
- Sub-word extension: SW 0x80FF7F01 @0x1010.
  - LB @0x1013 -> 0xFFFFFF80.
  - LBU @0x1013 -> 0x00000080.
  - LH @0x1012 -> 0xFFFF80FF.
  - LHU @0x1010 -> 0x00007F01.
  - Then SB 0xAA @0x1011 and LW @0x1010 -> 0x80FFAA01.
- Back-pressure: issue 4 back-to-back LWs with RspReady low for 3 cycles -> ReqReady=0 and the first response is held stable. Releasing RspReady -> 4 responses in consecutive cycles, in order.
- Errors (macro defined):
  - LW @0x0FFC -> RspErr=1, data 0.
  - SW @0x2000 -> RspErr=1 and no array change.
  - LH @0x1001 -> RspErr=1.
- Errors (macro undefined): SW 0x12345678 @0x2004, then LW @0x1004 -> 0x12345678 (index wraps), RspErr=0.

Source files
------------

// File: rtl/d_mem_rsp_if.sv
// Load/store request and response bundle between the core's data port
// (master) and the data-memory responder (slave).
interface d_mem_rsp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr_en;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_wr_en, req_addr, req_funct3, req_wr_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_err
    );

    modport slave (
        input  req_valid, req_wr_en, req_addr, req_funct3, req_wr_data, rsp_ready,
        output req_ready, rsp_valid, rsp_rd_data, rsp_err
    );
endinterface

// File: rtl/d_mem_rsp.sv
// Data-memory responder: one load/store per cycle over valid/ready, served
// from a word array at [D_MEM_OFFSET, D_MEM_OFFSET+D_MEM_SIZE). Responses are
// registered; load data is sign/zero extended according to funct3.
// Optional feature macro: DMEM_RANGE_CHK_EN (range/alignment/funct3 errors).
// Without it, RspErr is 0, the index wraps, low address bits of halfword and
// word accesses are ignored and invalid funct3 behaves as a word access.
// D_MEM_OFFSET must be word aligned (low two bits are never borrowed from).
module d_mem_rsp #(
    parameter logic [31:0] D_MEM_OFFSET = 32'h0000_1000,
    parameter logic [31:0] D_MEM_SIZE   = 32'h0000_1000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    d_mem_rsp_if.slave   bus
);

    localparam int unsigned AW    = $clog2(D_MEM_SIZE);
    localparam int unsigned WORDS = D_MEM_SIZE / 32'd4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Pick the addressed byte/halfword and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input size_e       sz,
                                                input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    r = {{24{sext & b[7]}}, b};
            SZ_H:    r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic [31:0]   mem_q [0:WORDS-1];
    logic [AW-3:0] idx_s;
    logic [1:0]    lane_s;
    size_e         size_s;
    logic          sext_s;
    logic          err_s;
    logic          accept_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic [31:0]   load_data_s;

    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rd_data_q, rsp_rd_data_d;
    logic          rsp_err_q, rsp_err_d;

    assign lane_s   = bus.req_addr[1:0];
    assign accept_s = bus.req_valid && bus.req_ready;

`ifdef DMEM_RANGE_CHK_EN
    // Legal funct3 encodings for loads and stores.
    function automatic logic f3_valid(input logic wr, input logic [2:0] f3);
        logic ok;
        if (wr) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    logic [29:0] off_w_s;
    logic        range_err_s;

    assign off_w_s     = bus.req_addr[31:2] - D_MEM_OFFSET[31:2];
    assign idx_s       = off_w_s[AW-3:0];
    assign range_err_s = |off_w_s[29:AW-2];

    // Flag out-of-range, misaligned and illegal-funct3 requests.
    always_comb begin
        err_s = 1'b0;
        if (range_err_s || !f3_valid(bus.req_wr_en, bus.req_funct3)) begin
            err_s = 1'b1;
        end else if (size_s == SZ_H && bus.req_addr[0]) begin
            err_s = 1'b1;
        end else if (size_s == SZ_W && (bus.req_addr[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end
`else
    // Index wraps within the array; upper address bits are ignored.
    assign idx_s = bus.req_addr[AW-1:2] - D_MEM_OFFSET[AW-1:2];
    assign err_s = 1'b0;
`endif

    // Decode access size and signedness; unknown encodings fall back to word.
    always_comb begin
        size_s = SZ_W;
        sext_s = 1'b0;
        if (bus.req_wr_en) begin
            case (bus.req_funct3)
                3'b000:  size_s = SZ_B;
                3'b001:  size_s = SZ_H;
                default: size_s = SZ_W;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000:  begin size_s = SZ_B; sext_s = 1'b1; end
                3'b001:  begin size_s = SZ_H; sext_s = 1'b1; end
                3'b100:  size_s = SZ_B;
                3'b101:  size_s = SZ_H;
                default: size_s = SZ_W;
            endcase
        end
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = bus.req_wr_data;
        case (size_s)
            SZ_B: begin
                be_s    = 4'b0001 << lane_s;
                wdata_s = {4{bus.req_wr_data[7:0]}};
            end
            SZ_H: begin
                be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{bus.req_wr_data[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = bus.req_wr_data;
            end
        endcase
    end

    assign load_data_s = load_extend(mem_q[idx_s], lane_s, size_s, sext_s);

    // Array write on the accepting edge; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept_s && bus.req_wr_en && !err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_q[idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
                end
            end
        end
    end

    // Response next state: load a new response on accept, drop it when consumed.
    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_rd_data_d = rsp_rd_data_q;
        rsp_err_d     = rsp_err_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_s;
            if (bus.req_wr_en || err_s) begin
                rsp_rd_data_d = 32'h0000_0000;
            end else begin
                rsp_rd_data_d = load_data_s;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d   = rsp_valid_q;
            rsp_rd_data_d = rsp_rd_data_q;
            rsp_err_d     = rsp_err_q;
        end
    end

    // Response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_rd_data_q <= 32'h0000_0000;
            rsp_err_q     <= 1'b0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign bus.req_ready   = !rst_i && (!rsp_valid_q || bus.rsp_ready);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_d_mem_rsp.sv
// Directed bench for d_mem_rsp: vector table of single requests plus
// hand-written reset, back-pressure and reset-with-pending sequences.
module tb_d_mem_rsp;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_X  = 3'b011;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    d_mem_rsp_if bus();

    d_mem_rsp dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.exp_d = exp_d; v.exp_e = exp_e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        bus.req_valid   = 1'b1;
        bus.req_wr_en   = wr;
        bus.req_funct3  = f3;
        bus.req_addr    = addr;
        bus.req_wr_data = wd;
    endtask

    // One request, wait (bounded) for acceptance, check the response next cycle.
    task automatic run_vec(input int i, input vec_t v);
        int waitc;
        @(negedge clk);
        drive(v.wr, v.f3, v.addr, v.wd);
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk($sformatf("vec%0d_ready", i), {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk($sformatf("vec%0d_valid", i), {31'd0, bus.rsp_valid}, 32'd1);
        chk($sformatf("vec%0d_data", i), bus.rsp_rd_data, v.exp_d);
        chk($sformatf("vec%0d_err", i), {31'd0, bus.rsp_err}, {31'd0, v.exp_e});
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Common vectors: round trip, sub-word extension, halfword store.
        add(1'b1, F_W,  32'h1004, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        add(1'b0, F_W,  32'h1004, 32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b1, F_W,  32'h1010, 32'h80FF7F01, 32'h0000_0000, 1'b0);
        add(1'b0, F_B,  32'h1013, 32'h0,        32'hFFFFFF80, 1'b0);
        add(1'b0, F_BU, 32'h1013, 32'h0,        32'h00000080, 1'b0);
        add(1'b0, F_H,  32'h1012, 32'h0,        32'hFFFF80FF, 1'b0);
        add(1'b0, F_HU, 32'h1010, 32'h0,        32'h00007F01, 1'b0);
        add(1'b1, F_B,  32'h1011, 32'h000000AA, 32'h0000_0000, 1'b0);
        add(1'b0, F_W,  32'h1010, 32'h0,        32'h80FFAA01, 1'b0);
        add(1'b1, F_W,  32'h1014, 32'h11223344, 32'h0000_0000, 1'b0);
        add(1'b1, F_H,  32'h1016, 32'hFFFFBEEF, 32'h0000_0000, 1'b0);
        add(1'b0, F_W,  32'h1014, 32'h0,        32'hBEEF3344, 1'b0);
        add(1'b0, F_H,  32'h1016, 32'h0,        32'hFFFFBEEF, 1'b0);
        add(1'b0, F_BU, 32'h1014, 32'h0,        32'h00000044, 1'b0);
        add(1'b0, F_B,  32'h1015, 32'h0,        32'h00000033, 1'b0);
        for (int k = 0; k < 4; k++) begin
            add(1'b1, F_W, 32'h1020 + 32'(4*k), 32'hA0000001 + 32'(k), 32'h0, 1'b0);
        end
`ifdef DMEM_RANGE_CHK_EN
        add(1'b1, F_W,  32'h1000, 32'h0BADF00D, 32'h0, 1'b0);
        add(1'b0, F_W,  32'h0FFC, 32'h0,        32'h0, 1'b1);
        add(1'b1, F_W,  32'h2000, 32'hFFFFFFFF, 32'h0, 1'b1);
        add(1'b0, F_W,  32'h1000, 32'h0,        32'h0BADF00D, 1'b0);
        add(1'b0, F_H,  32'h1001, 32'h0,        32'h0, 1'b1);
        add(1'b0, F_W,  32'h1002, 32'h0,        32'h0, 1'b1);
        add(1'b0, F_X,  32'h1000, 32'h0,        32'h0, 1'b1);
        add(1'b1, F_X,  32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
        add(1'b0, F_W,  32'h1000, 32'h0,        32'h0BADF00D, 1'b0);
        add(1'b1, F_W,  32'h1FFC, 32'h77777777, 32'h0, 1'b0);
        add(1'b0, F_W,  32'h1FFC, 32'h0,        32'h77777777, 1'b0);
        add(1'b0, F_W,  32'h2000, 32'h0,        32'h0, 1'b1);
`else
        add(1'b1, F_W,  32'h2004, 32'h12345678, 32'h0, 1'b0);
        add(1'b0, F_W,  32'h1004, 32'h0,        32'h12345678, 1'b0);
        add(1'b0, F_W,  32'h1006, 32'h0,        32'h12345678, 1'b0);
        add(1'b1, F_W,  32'h1FFC, 32'hCAFEF00D, 32'h0, 1'b0);
        add(1'b0, F_W,  32'h0FFC, 32'h0,        32'hCAFEF00D, 1'b0);
        add(1'b1, F_W,  32'h1000, 32'h1357A5C3, 32'h0, 1'b0);
        add(1'b0, F_H,  32'h1001, 32'h0,        32'hFFFFA5C3, 1'b0);
        add(1'b0, F_X,  32'h1000, 32'h0,        32'h1357A5C3, 1'b0);
        add(1'b1, F_X,  32'h1008, 32'h24682468, 32'h0, 1'b0);
        add(1'b0, F_W,  32'h1008, 32'h0,        32'h24682468, 1'b0);
`endif

        // Reset held 3 cycles with a store presented: nothing accepted.
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        drive(1'b1, F_W, 32'h1004, 32'hFFFFFFFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("rst_rsp_data", bus.rsp_rd_data, 32'd0);
            chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        end
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        // Table-driven single requests.
        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
        end

        // Back-pressure: 4 back-to-back LWs, response held for 3 cycles.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(1'b0, F_W, 32'h1020, 32'h0);
        @(negedge clk);
        bus.req_addr = 32'h1024;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_hold_data", bus.rsp_rd_data, 32'hA0000001);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_rsp0_data", bus.rsp_rd_data, 32'hA0000001);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_rsp%0d_valid", k), {31'd0, bus.rsp_valid}, 32'd1);
            chk($sformatf("bp_rsp%0d_data", k), bus.rsp_rd_data, 32'hA0000001 + 32'(k));
            if (k < 3) begin
                bus.req_addr = 32'h1024 + 32'(4*k);
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("bp_drain_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Reset with a pending response and a blocked store: both discarded.
        bus.rsp_ready = 1'b0;
        drive(1'b0, F_W, 32'h1010, 32'h0);
        @(negedge clk);
        chk("pend_valid", {31'd0, bus.rsp_valid}, 32'd1);
        drive(1'b1, F_W, 32'h1010, 32'hFFFFFFFF);
        rst = 1'b1;
        #1;
        chk("pend_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("pend_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("pend_rst_ready2", {31'd0, bus.req_ready}, 32'd0);
        end
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("pend_post_ready", {31'd0, bus.req_ready}, 32'd1);
        begin
            vec_t v;
            v.wr = 1'b0; v.f3 = F_W; v.addr = 32'h1010; v.wd = 32'h0;
            v.exp_d = 32'h80FFAA01; v.exp_e = 1'b0;
            run_vec(999, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
